// File: rtl/clkdivn_pkg.sv
// Shared defaults for the programmable even-ratio clock divider.
// Half-period encodings of the legacy fixed /2 and /4 modes are kept for callers.
package clkdivn_pkg;

  localparam int CW_DEF       = 4;
  localparam int HALF_DIV2    = 0;
  localparam int HALF_DIV4    = 1;
  localparam int RST_HALF_DEF = HALF_DIV4;

endpackage

// File: rtl/clkdivn.sv
// Programmable even-ratio divider: clkout period is 2*(act_half+1) clkin cycles, 50:50 duty.
// Ratio changes are held pending and take effect only at a rising clkout boundary.
module clkdivn
  import clkdivn_pkg::*;
#(
  parameter int CW       = CW_DEF,
  parameter int RST_HALF = RST_HALF_DEF
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic [CW-1:0] div_half,
  input  logic          div_load,
  output logic          clkout,
  output logic          rise_stb,
  output logic          fall_stb,
  output logic          busy,
  output logic [CW-1:0] cur_half
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] act_half;
  logic [CW-1:0] pend_half;
  logic          pend;
  logic          at_bound;

  assign at_bound = (cnt == act_half);

  // NOTE: every state register uses <= so all updates see pre-edge values;
  // the apply below must read the old pend/pend_half even when a load lands on the same edge.
  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt       <= '0;
      clkout    <= 1'b0;
      act_half  <= CW'(RST_HALF);
      pend_half <= '0;
      pend      <= 1'b0;
    end else begin
      if (at_bound) begin
        cnt    <= '0;
        clkout <= ~clkout;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // Apply only as clkout rises, so the new ratio spans a whole high+low period.
      if (at_bound && !clkout && pend) begin
        act_half <= pend_half;
        pend     <= 1'b0;
      end

      // A coincident load wins over the clear above and stays pending for the next rise.
      if (div_load) begin
        pend_half <= div_half;
        pend      <= 1'b1;
      end
    end
  end

  assign rise_stb = at_bound & ~clkout;
  assign fall_stb = at_bound & clkout;
  assign busy     = pend;
  assign cur_half = act_half;

endmodule

// File: tb/tb_clkdivn.sv
// Scoreboard bench for clkdivn: a driver pushes hand-derived per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_clkdivn;

  localparam int CW = 4;

  logic          clkin = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] div_half = '0;
  logic          div_load = 1'b0;
  logic          clkout;
  logic          rise_stb;
  logic          fall_stb;
  logic          busy;
  logic [CW-1:0] cur_half;

  clkdivn #(.CW(CW), .RST_HALF(1)) dut (
    .clkin    (clkin),
    .rst      (rst),
    .div_half (div_half),
    .div_load (div_load),
    .clkout   (clkout),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .busy     (busy),
    .cur_half (cur_half)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    string      seg;
    int         cyc;
    logic [7:0] val;  // {clkout, rise_stb, fall_stb, busy, cur_half}
  } exp_t;

  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  string seg     = "reset";

  task automatic check(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got ck/rise/fall/busy=%b%b%b%b cur=%h, expected ck/rise/fall/busy=%b%b%b%b cur=%h",
               name, c, act[7], act[6], act[5], act[4], act[3:0], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  // ck: 'L' low, 'H' high, 'r' low with rise_stb, 'f' high with fall_stb.
  // Inputs driven in a cycle are sampled at the following clkin edge; ld < 0 means no load.
  task automatic row(input int n, input byte ck, input bit bz, input int cu, input int ld, input bit rs);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clkin);
      #1;
      e.seg = seg;
      e.cyc = cyc;
      e.val = {(ck == "H" || ck == "f"), (ck == "r"), (ck == "f"), bz, 4'(cu)};
      exp_q.push_back(e);
      rst      = rs;
      div_load = (ld >= 0);
      div_half = (ld >= 0) ? 4'(ld) : 4'h0;
      cyc++;
    end
  endtask

  always @(negedge clkin) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.seg, e.cyc, {clkout, rise_stb, fall_stb, busy, cur_half}, e.val);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clkin);

    // Release from reset with /4: 0,0,1,1 repeating
    seg = "reset";
    row(1, "L", 0, 1, -1, 0);
    row(1, "r", 0, 1, -1, 0);
    row(1, "H", 0, 1, -1, 0);
    row(1, "f", 0, 1, -1, 0);
    row(1, "L", 0, 1, -1, 0);
    row(1, "r", 0, 1, -1, 0);
    row(1, "H", 0, 1, -1, 0);
    row(1, "f", 0, 1, -1, 0);

    // Load /2 while high; current /4 period completes first
    seg = "to_div2";
    row(1, "L", 0, 1, -1, 0);
    row(1, "r", 0, 1, -1, 0);
    row(1, "H", 0, 1,  0, 0);
    row(1, "f", 1, 1, -1, 0);
    row(1, "L", 1, 1, -1, 0);
    row(1, "r", 1, 1, -1, 0);
    row(1, "f", 0, 0, -1, 0);
    row(1, "r", 0, 0, -1, 0);
    row(1, "f", 0, 0, 15, 0);

    // /32: 16 high then 16 low
    seg = "div32";
    row(1,  "r", 1, 0,  -1, 0);
    row(15, "H", 0, 15, -1, 0);
    row(1,  "f", 0, 15, -1, 0);

    // Load 3 then 5 during the low phase; only 5 (period 12) takes effect
    seg = "last_wins";
    row(2, "L", 0, 15, -1, 0);
    row(1, "L", 0, 15,  3, 0);
    row(3, "L", 1, 15, -1, 0);
    row(1, "L", 1, 15,  5, 0);
    row(8, "L", 1, 15, -1, 0);
    row(1, "r", 1, 15, -1, 0);
    row(5, "H", 0, 5,  -1, 0);
    row(1, "f", 0, 5,  -1, 0);
    row(5, "L", 0, 5,  -1, 0);

    // Load on the rising-boundary edge with nothing pending: applies one period later
    seg = "coincident";
    row(1, "r", 0, 5,  2, 0);
    row(5, "H", 1, 5, -1, 0);
    row(1, "f", 1, 5, -1, 0);
    row(5, "L", 1, 5, -1, 0);
    row(1, "r", 1, 5, -1, 0);
    row(2, "H", 0, 2, -1, 0);
    row(1, "f", 0, 2, -1, 0);
    row(2, "L", 0, 2, -1, 0);
    row(1, "r", 0, 2, -1, 0);

    // One-cycle reset mid high phase with a pending request and a coincident load
    seg = "mid_reset";
    row(1, "H", 0, 2,  7, 0);
    row(1, "H", 1, 2,  9, 1);
    row(1, "L", 0, 1, -1, 0);
    row(1, "r", 0, 1, -1, 0);
    row(1, "H", 0, 1, -1, 0);
    row(1, "f", 0, 1, -1, 0);
    row(1, "L", 0, 1, -1, 0);
    row(1, "r", 0, 1, -1, 0);
    row(1, "H", 0, 1, -1, 0);

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clkin);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clkdivn.md
Name: clkdivn

Overview:
Programmable even-ratio clock divider producing a 50:50 mark-space clkout from clkin.
Supersedes the fixed /2-/4 divider. Ratio is N = 2*(half+1), where half is a CW-bit half-period count, giving N from 2 to 2^(CW+1).
Ratio changes are queued and applied only at the low-to-high boundary of clkout, so no runt pulse is ever produced.
Also provides pre-edge strobes so logic in the clkin domain can use clock enables aligned to clkout edges.

Parameters:
CW, 4, width of the half-period counter and of the div_half input
RST_HALF, 1, half-period count loaded at reset; 0 gives /2, 1 gives /4 (default is /4)

Ports:
clkin  input  1  divider source clock; all state updates on posedge
rst  input  1  synchronous reset, active-high
div_half  input  CW  requested half-period count; new ratio = 2*(div_half+1)
div_load  input  1  when high at a clkin edge, samples div_half into the pending register
clkout  output  1  divided clock, registered, 50:50 duty cycle
rise_stb  output  1  high for the one clkin cycle whose closing edge raises clkout
fall_stb  output  1  high for the one clkin cycle whose closing edge lowers clkout
busy  output  1  a queued ratio change has not yet been applied
cur_half  output  CW  half-period count currently in force

Behaviour:
- State registers: cnt[CW-1:0], clkout, act_half[CW-1:0] (drives cur_half), pend_half[CW-1:0], pend (drives busy).
- Reset, sampled at a clkin edge with rst=1:
  - cnt=0, clkout=0, act_half=RST_HALF, pend_half=0, pend=0.
  - rst overrides div_load and any in-progress count, including mid-period. Any pending request is discarded.
- Counting, every clkin edge with rst=0:
  - if cnt==act_half: cnt<=0 and clkout<=~clkout;
  - otherwise cnt<=cnt+1.
  - Each clkout phase therefore lasts exactly act_half+1 clkin cycles.
- First edge after reset: clkout rises on the (act_half+1)th clkin edge after rst deasserts.
  - RST_HALF=1: clkout goes high at edge 2, low at edge 4, period 4.
- Apply rule:
  - On an edge where cnt==act_half and clkout==0 (the rising boundary) and pend==1: act_half<=pend_half and pend<=0.
  - The new ratio governs the high phase that starts at that edge.
  - Changes are never applied at the falling boundary, so every clkout period is symmetric.
- Load rule:
  - div_load=1 at an edge sets pend_half<=div_half and pend<=1.
  - A later load before application overwrites the earlier one; the last request wins.
- Simultaneous load and rising boundary:
  - The apply uses the registered pend/pend_half values from before the edge.
  - The new load becomes pending (pend stays 1) and is applied at the next rising boundary.
  - If pend was 0, nothing is applied at that edge.
- Loading the value already in force is legal. It sets busy until the next rising boundary, with no visible effect on clkout.
- Strobes (combinational from registers only, glitch-free relative to clkin):
  - rise_stb = (cnt==act_half) & ~clkout
  - fall_stb = (cnt==act_half) & clkout
  - With act_half=0 (/2), the strobes alternate every cycle. Exactly one of them is high in every cycle.
- Counter never exceeds act_half.
  - When a smaller ratio is applied, cnt is already 0 at the boundary, so no wrap or overrun is possible.
  - Maximum cnt = 2^CW-1; no extra width is needed.
- clkout is a flop output and must not be gated or combined combinationally downstream inside this block.

Decomposition:
- Shared header clkdiv_defs: CW default, RST_HALF default, localparams for the /2 (0) and /4 (1) encodings of the legacy modes.
- Single module. The counter, the pending register and the strobe decode are tightly coupled at the boundary edge, so no sub-module is natural.

Test Plan:
- Reset with RST_HALF=1, release rst -> clkout 0,0,1,1,0,0,1,1 at edges 0..7; rise_stb high in cycle 1, fall_stb high in cycle 3; cur_half=1, busy=0.
- From /4, pulse div_load with div_half=0 while clkout high -> busy=1 until next rising boundary; clkout completes the current 4-cycle period, then toggles every edge; cur_half=0.
- From /2, load div_half=15 (CW=4) -> after the boundary, clkout high 16 cycles, low 16 cycles; cnt peaks at 15 with no wrap.
- Load 3 then 5 before the boundary -> only 5 is applied (period 12); period 8 is never seen.
- div_load coincident with the rising-boundary edge while pend=0 -> ratio unchanged this period, busy=1, new ratio applies one full period later.
- Assert rst for 1 cycle mid high phase with pend=1 -> next edge clkout=0, cnt=0, busy=0, cur_half=RST_HALF; the restart timing matches the first scenario.
